data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 17 +
 rtl/data_mem_ctrl_if.sv | 22 ++
 rtl/data_mem_ctrl_lane_align.sv | 55 +++++
 rtl/data_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Load/store definitions shared by the memory controller and the load-extension stage.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b011;
    localparam logic [2:0] LS_HU = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-wide data memory bus between the controller (master) and the memory (slave).
interface data_mem_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational lane steering: byte enables, store replication, access checks and load lane extraction.
module lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  ls_type,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        access_err,
    input  logic [2:0]  load_type,
    input  logic [1:0]  load_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_lane
);

    logic [31:0] shifted;

    always_comb begin
        be         = '0;
        wdata      = '0;
        access_err = 1'b0;
        case (ls_type)
            LS_B, LS_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            LS_H, LS_HU: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                access_err = addr_lo[0];
            end
            LS_W: begin
                be         = 4'b1111;
                wdata      = store_data;
                access_err = |addr_lo;
            end
            default: access_err = 1'b1;
        endcase
        // Unsigned kinds are meaningless for stores.
        if (is_store && ls_type > LS_W)
            access_err = 1'b1;
    end

    always_comb begin
        shifted = rdata >> {load_off, 3'b000};
        case (load_type)
            LS_B, LS_BU: load_lane = {24'b0, shifted[7:0]};
            LS_H, LS_HU: load_lane = {16'b0, shifted[15:0]};
            default:     load_lane = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store controller: IDLE -> REQ -> RESP -> DONE with ack timeout.
module data_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            ls_type,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  timeout,
    output logic [31:0]           load_raw,
    data_mem_ctrl_if.master       mem
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  ld_type_q;
    logic [1:0]  ld_off_q;
    logic        ld_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic [3:0]  be;
    logic [31:0] wdata, load_lane;
    logic        access_err;

    lane_align u_lane_align (
        .ls_type    (ls_type),
        .is_store   (is_store),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .be         (be),
        .wdata      (wdata),
        .access_err (access_err),
        .load_type  (ld_type_q),
        .load_off   (ld_off_q),
        .rdata      (mem.mem_rdata),
        .load_lane  (load_lane)
    );

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ld_type_q <= '0;
            ld_off_q  <= '0;
            ld_q      <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
            load_raw  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    ld_type_q <= ls_type;
                    ld_off_q  <= addr[1:0];
                    ld_q      <= !is_store;
                    if (access_err) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state    <= REQ;
                        wait_cnt <= '0;
                        req_q    <= 1'b1;
                        we_q     <= is_store;
                        addr_q   <= {addr[31:2], 2'b00};
                        be_q     <= be;
                        wdata_q  <= is_store ? wdata : '0;
                    end
                end
                REQ: begin
                    if (!mem.mem_ack)
                        wait_cnt <= wait_cnt + 8'd1;
                    // Bus drops on the same edge as either exit from REQ.
                    if (mem.mem_ack || wait_cnt == WAIT_LAST) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        be_q    <= '0;
                        wdata_q <= '0;
                    end
                    if (mem.mem_ack) begin
                        if (ld_q)
                            load_raw <= load_lane;
                        state <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                RESP: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    timeout <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl, built with TIMEOUT=4.
module tb_data_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  ls_type = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, err, timeout;
    logic [31:0] load_raw;
    int unsigned total_cnt = 0;
    int unsigned pass_cnt = 0;
    int unsigned done_cnt = 0;

    data_mem_ctrl_if mem();

    data_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .ls_type    (ls_type),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .timeout    (timeout),
        .load_raw   (load_raw),
        .mem        (mem)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] ty, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1;
        is_store = st;
        ls_type = ty;
        addr = a;
        store_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b0 || timeout !== 1'b0) $display("FAIL rst_err_to: got %b%b want 00", err, timeout); else pass_cnt++;
        total_cnt++; if (mem.mem_req !== 1'b0 || mem.mem_we !== 1'b0) $display("FAIL rst_req_we: got %b%b want 00", mem.mem_req, mem.mem_we); else pass_cnt++;
        total_cnt++; if (mem.mem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 00000000", mem.mem_addr); else pass_cnt++;
        total_cnt++; if (mem.mem_be !== 4'h0) $display("FAIL rst_be: got %b want 0000", mem.mem_be); else pass_cnt++;
        total_cnt++; if (mem.mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 00000000", mem.mem_wdata); else pass_cnt++;
        total_cnt++; if (load_raw !== 32'h0) $display("FAIL rst_load_raw: got %h want 00000000", load_raw); else pass_cnt++;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        int unsigned d0;
        d0 = done_cnt;
        issue(1'b1, LS_W, 32'h0000_0104, 32'hDEAD_BEEF);
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_req !== 1'b1 || busy !== 1'b1) $display("FAIL sw_req_busy: got %b%b want 11", mem.mem_req, busy); else pass_cnt++;
        total_cnt++; if (mem.mem_we !== 1'b1) $display("FAIL sw_we: got %b want 1", mem.mem_we); else pass_cnt++;
        total_cnt++; if (mem.mem_addr !== 32'h0000_0104) $display("FAIL sw_addr: got %h want 00000104", mem.mem_addr); else pass_cnt++;
        total_cnt++; if (mem.mem_be !== 4'b1111) $display("FAIL sw_be: got %b want 1111", mem.mem_be); else pass_cnt++;
        total_cnt++; if (mem.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata: got %h want deadbeef", mem.mem_wdata); else pass_cnt++;
        step();
        total_cnt++; if (mem.mem_req !== 1'b1 || mem.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_hold: got %b %h want 1 deadbeef", mem.mem_req, mem.mem_wdata); else pass_cnt++;
        mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        total_cnt++; if (mem.mem_req !== 1'b0 || mem.mem_be !== 4'h0 || mem.mem_wdata !== 32'h0) $display("FAIL sw_bus_idle: got %b %b %h want 0 0000 00000000", mem.mem_req, mem.mem_be, mem.mem_wdata); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL sw_resp_done: got %b want 0", done); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || err !== 1'b0 || timeout !== 1'b0) $display("FAIL sw_done: got %b%b%b want 100", done, err, timeout); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL sw_after: got %b%b want 00", done, busy); else pass_cnt++;
        total_cnt++; if (done_cnt != d0 + 1) $display("FAIL sw_done_count: got %0d want %0d", done_cnt - d0, 1); else pass_cnt++;
    endtask

    task automatic test_load_byte_half();
        issue(1'b0, LS_B, 32'h0000_0203, 32'h0);
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b0) $display("FAIL lb_req_we: got %b%b want 10", mem.mem_req, mem.mem_we); else pass_cnt++;
        total_cnt++; if (mem.mem_addr !== 32'h0000_0200) $display("FAIL lb_addr: got %h want 00000200", mem.mem_addr); else pass_cnt++;
        total_cnt++; if (mem.mem_be !== 4'b1000) $display("FAIL lb_be: got %b want 1000", mem.mem_be); else pass_cnt++;
        mem.mem_rdata = 32'h80AA_BBCC; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0; mem.mem_rdata = 32'hFFFF_FFFF;
        total_cnt++; if (load_raw !== 32'h0000_0080) $display("FAIL lb_load_raw: got %h want 00000080", load_raw); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL lb_done_n3: got %b%b want 10", done, err); else pass_cnt++;
        step();
        issue(1'b0, LS_H, 32'h0000_0202, 32'h0);
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_be !== 4'b1100) $display("FAIL lh_be: got %b want 1100", mem.mem_be); else pass_cnt++;
        mem.mem_rdata = 32'h80AA_BBCC; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
        total_cnt++; if (load_raw !== 32'h0000_80AA) $display("FAIL lh_load_raw: got %h want 000080aa", load_raw); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1) $display("FAIL lh_done: got %b want 1", done); else pass_cnt++;
        step();
    endtask

    task automatic test_store_half_byte();
        issue(1'b1, LS_H, 32'h0000_0010, 32'h1234_ABCD);
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_be !== 4'b0011) $display("FAIL sh_be: got %b want 0011", mem.mem_be); else pass_cnt++;
        total_cnt++; if (mem.mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want abcdabcd", mem.mem_wdata); else pass_cnt++;
        mem.mem_rdata = 32'h1111_1111; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        step();
        total_cnt++; if (done !== 1'b1 || load_raw !== 32'h0000_80AA) $display("FAIL sh_done_keep: got %b %h want 1 000080aa", done, load_raw); else pass_cnt++;
        step();
        issue(1'b1, LS_B, 32'h0000_0013, 32'h0000_005A);
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_be !== 4'b1000 || mem.mem_wdata !== 32'h5A5A_5A5A) $display("FAIL sb_be_wdata: got %b %h want 1000 5a5a5a5a", mem.mem_be, mem.mem_wdata); else pass_cnt++;
        mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        step(); step();
    endtask

    task automatic test_access_errors();
        logic        st_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  ty_tab [4] = '{LS_W, LS_HU, LS_BU, 3'b101};
        logic [31:0] ad_tab [4] = '{32'h6, 32'h3, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(st_tab[i], ty_tab[i], ad_tab[i], 32'hFFFF_FFFF);
            step(); start = 1'b0;
            total_cnt++; if (mem.mem_req !== 1'b0) $display("FAIL err%0d_no_req: got %b want 0", i, mem.mem_req); else pass_cnt++;
            total_cnt++; if (done !== 1'b1 || err !== 1'b1 || timeout !== 1'b0 || busy !== 1'b1) $display("FAIL err%0d_flags: got d%b e%b t%b b%b want d1 e1 t0 b1", i, done, err, timeout, busy); else pass_cnt++;
            total_cnt++; if (load_raw !== 32'h0000_80AA) $display("FAIL err%0d_load_raw: got %h want 000080aa", i, load_raw); else pass_cnt++;
            step();
            total_cnt++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) $display("FAIL err%0d_after: got %b%b%b want 000", i, done, err, busy); else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        issue(1'b0, LS_W, 32'h0000_0040, 32'h0);
        step(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            total_cnt++; if (mem.mem_req !== 1'b1 || done !== 1'b0) $display("FAIL to_wait%0d: got req%b done%b want req1 done0", i, mem.mem_req, done); else pass_cnt++;
            step();
        end
        total_cnt++; if (mem.mem_req !== 1'b0) $display("FAIL to_req_drop: got %b want 0", mem.mem_req); else pass_cnt++;
        total_cnt++; if (done !== 1'b1 || timeout !== 1'b1 || err !== 1'b0) $display("FAIL to_flags: got d%b t%b e%b want d1 t1 e0", done, timeout, err); else pass_cnt++;
        mem.mem_rdata = 32'hCAFE_F00D; mem.mem_ack = 1'b1;
        step();
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) $display("FAIL to_after: got b%b d%b t%b want 000", busy, done, timeout); else pass_cnt++;
        step(); mem.mem_ack = 1'b0;
        total_cnt++; if (load_raw !== 32'h0000_80AA || busy !== 1'b0 || mem.mem_req !== 1'b0) $display("FAIL to_stray_ack: got %h b%b r%b want 000080aa b0 r0", load_raw, busy, mem.mem_req); else pass_cnt++;
        issue(1'b0, LS_W, 32'h0000_0044, 32'h0);
        step(); start = 1'b0;
        step(); step(); step();
        total_cnt++; if (mem.mem_req !== 1'b1) $display("FAIL to_last_req: got %b want 1", mem.mem_req); else pass_cnt++;
        mem.mem_rdata = 32'h1122_3344; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        total_cnt++; if (load_raw !== 32'h1122_3344 || done !== 1'b0) $display("FAIL to_last_ack: got %h d%b want 11223344 d0", load_raw, done); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || timeout !== 1'b0) $display("FAIL to_last_done: got d%b t%b want d1 t0", done, timeout); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, LS_BU, 32'h0000_0101, 32'h0);
        step();
        issue(1'b0, LS_W, 32'h0000_0300, 32'h0);
        total_cnt++; if (mem.mem_addr !== 32'h0000_0100 || mem.mem_be !== 4'b0010) $display("FAIL b2b_first: got %h %b want 00000100 0010", mem.mem_addr, mem.mem_be); else pass_cnt++;
        mem.mem_rdata = 32'h0000_7F00; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        total_cnt++; if (mem.mem_req !== 1'b0) $display("FAIL b2b_start_ignored: got %b want 0", mem.mem_req); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || load_raw !== 32'h0000_007F) $display("FAIL b2b_first_done: got %b %h want 1 0000007f", done, load_raw); else pass_cnt++;
        step();
        total_cnt++; if (busy !== 1'b0 || mem.mem_req !== 1'b0) $display("FAIL b2b_idle: got b%b r%b want 00", busy, mem.mem_req); else pass_cnt++;
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 32'h0000_0300 || mem.mem_be !== 4'b1111) $display("FAIL b2b_second: got %b %h %b want 1 00000300 1111", mem.mem_req, mem.mem_addr, mem.mem_be); else pass_cnt++;
        mem.mem_rdata = 32'h89AB_CDEF; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        total_cnt++; if (load_raw !== 32'h89AB_CDEF) $display("FAIL b2b_second_data: got %h want 89abcdef", load_raw); else pass_cnt++;
        step(); step();
    endtask

    task automatic test_reset_abort();
        int unsigned d0;
        issue(1'b1, LS_W, 32'h0000_0500, 32'hDEAD_BEEF);
        step(); start = 1'b0;
        d0 = done_cnt;
        total_cnt++; if (mem.mem_req !== 1'b1) $display("FAIL ra_req: got %b want 1", mem.mem_req); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (mem.mem_req !== 1'b0 || busy !== 1'b0 || mem.mem_be !== 4'h0) $display("FAIL ra_immediate: got r%b b%b be%b want 0 0 0000", mem.mem_req, busy, mem.mem_be); else pass_cnt++;
        step(); step();
        total_cnt++; if (done_cnt != d0 || load_raw !== 32'h0) $display("FAIL ra_no_done: got %0d %h want 0 00000000", done_cnt - d0, load_raw); else pass_cnt++;
        rst_n = 1'b1;
        issue(1'b0, LS_W, 32'h0000_0008, 32'h0);
        step(); start = 1'b0;
        total_cnt++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 32'h0000_0008) $display("FAIL ra_restart: got %b %h want 1 00000008", mem.mem_req, mem.mem_addr); else pass_cnt++;
        mem.mem_rdata = 32'h55AA_55AA; mem.mem_ack = 1'b1;
        step(); mem.mem_ack = 1'b0;
        step();
        total_cnt++; if (done !== 1'b1 || err !== 1'b0 || load_raw !== 32'h55AA_55AA) $display("FAIL ra_restart_done: got d%b e%b %h want d1 e0 55aa55aa", done, err, load_raw); else pass_cnt++;
        step();
    endtask

    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        #2;
        test_reset();
        test_store_word();
        test_load_byte_half();
        test_store_half_byte();
        test_access_errors();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
